// File: rtl/accum_pkg.sv
// Shared defaults and the counter-width rule for the accumulator bank.
package accum_pkg;

  localparam int DEF_THRESHOLD = 255;
  localparam int DEF_INC_STEP  = 8;
  localparam int DEF_DEC_STEP  = 1;

  // Headroom covers threshold, the larger step and the full dither range, plus sign and guard bit.
  function automatic int count_w(input int thr, input int inc, input int dec, input int dw);
    int mx;
    mx = (inc > dec) ? inc : dec;
    return $clog2(thr + mx + (1 << dw)) + 2;
  endfunction

endpackage

// File: rtl/accum_lane.sv
// One signed accumulator lane with dithered up/down threshold triggers.
module accum_lane
  import accum_pkg::*;
#(
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int INC_STEP  = DEF_INC_STEP,
  parameter int DEC_STEP  = DEF_DEC_STEP,
  parameter int DITHER_W  = 0,
  parameter int BIDIR     = 1,
  parameter int LANE_IDX  = 0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       clear,
  input  logic       en,
  input  logic       inc,
  input  logic [7:0] rnd,
  output logic       up_hit,
  output logic       dn_hit,
  output logic       trig_up,
  output logic       trig_dn
);

  localparam int COUNT_W = count_w(THRESHOLD, INC_STEP, DEC_STEP, DITHER_W);
  localparam int WIDE_W  = COUNT_W + 17;
  localparam int DW1     = (DITHER_W == 0) ? 1 : DITHER_W;
  localparam int ROT     = LANE_IDX % DW1;
  localparam logic [15:0] DMASK = 16'((1 << DITHER_W) - 1);
  localparam logic signed [WIDE_W-1:0] THR   = WIDE_W'(THRESHOLD);
  localparam logic signed [WIDE_W-1:0] INC_W = WIDE_W'(INC_STEP);
  localparam logic signed [WIDE_W-1:0] DEC_W = WIDE_W'(DEC_STEP);

  logic signed [COUNT_W-1:0] count_p1;
  logic                      trig_up_p1, trig_dn_p1;
  logic [15:0]               draw_p0, drot_p0;
  logic signed [WIDE_W-1:0]  dith_p0, cur_p0, nxt_p0, res_p0;
  logic                      up_p0, dn_p0;

  // Stage p0: next count, dither and trigger decision
  always_comb begin
    draw_p0 = {8'h00, rnd} & DMASK;
    drot_p0 = ((draw_p0 << ROT) | (draw_p0 >> (DW1 - ROT))) & DMASK;
    dith_p0 = WIDE_W'($signed({1'b0, drot_p0}));
    cur_p0  = WIDE_W'(count_p1);
    nxt_p0  = inc ? (cur_p0 + INC_W) : (cur_p0 - DEC_W);
    up_p0   = en && ((nxt_p0 + dith_p0) >= THR);
    dn_p0   = en && (BIDIR != 0) && !up_p0 && ((nxt_p0 - dith_p0) <= -THR);
    res_p0  = nxt_p0;
    if (up_p0) begin
      res_p0 = nxt_p0 - THR;
    end else if (dn_p0) begin
      res_p0 = nxt_p0 + THR;
    end else if ((BIDIR == 0) && (nxt_p0 < 0)) begin
      res_p0 = '0;
    end
  end

  // Stage p1: registered count and one-cycle trigger pulses
  always_ff @(posedge clk_in) begin
    if (!rst_in || clear) begin
      count_p1   <= '0;
      trig_up_p1 <= 1'b0;
      trig_dn_p1 <= 1'b0;
    end else begin
      trig_up_p1 <= up_p0;
      trig_dn_p1 <= dn_p0;
      if (en) begin
        count_p1 <= COUNT_W'(res_p0);
      end
    end
  end

  assign up_hit  = up_p0;
  assign dn_hit  = dn_p0;
  assign trig_up = trig_up_p1;
  assign trig_dn = trig_dn_p1;

endmodule

// File: rtl/accum_bank.sv
// Bank of N_CH accumulator lanes with a saturating running count of all triggers.
module accum_bank
  import accum_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int INC_STEP  = DEF_INC_STEP,
  parameter int DEC_STEP  = DEF_DEC_STEP,
  parameter int DITHER_W  = 0,
  parameter int BIDIR     = 1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [7:0]      rnd_in,
  input  logic            prop_in,
  input  logic [N_CH-1:0] mask_in,
  input  logic [N_CH-1:0] inc_in,
  input  logic            clear_in,
  output logic [N_CH-1:0] trig_up_out,
  output logic [N_CH-1:0] trig_dn_out,
  output logic [15:0]     trig_total_out
);

  logic [N_CH-1:0] up_hit_p0, dn_hit_p0;
  logic [15:0]     total_p1;

  function automatic logic [15:0] popcount(input logic [N_CH-1:0] v);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < N_CH; i++) begin
      c = c + 16'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    accum_lane #(
      .THRESHOLD(THRESHOLD),
      .INC_STEP (INC_STEP),
      .DEC_STEP (DEC_STEP),
      .DITHER_W (DITHER_W),
      .BIDIR    (BIDIR),
      .LANE_IDX (i)
    ) u_lane (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clear  (clear_in),
      .en     (prop_in & mask_in[i]),
      .inc    (inc_in[i]),
      .rnd    (rnd_in),
      .up_hit (up_hit_p0[i]),
      .dn_hit (dn_hit_p0[i]),
      .trig_up(trig_up_out[i]),
      .trig_dn(trig_dn_out[i])
    );
  end

  // Stage p1: total advances together with the pulses it counts
  always_ff @(posedge clk_in) begin
    if (!rst_in || clear_in) begin
      total_p1 <= '0;
    end else begin
      total_p1 <= sat_add(total_p1, popcount(up_hit_p0 | dn_hit_p0));
    end
  end

  assign trig_total_out = total_p1;

endmodule

// File: tb/tb_accum_bank.sv
// Randomized and directed bench for accum_bank, three parameter sets against one arithmetic model.
module tb_accum_bank;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic       rst_in, prop_in, clear_in;
  logic [7:0] rnd_in, mask_in, inc_in;
  logic [7:0] up_a, dn_a, up_b, dn_b, up_c, dn_c;
  logic [15:0] tot_a, tot_b, tot_c;

  accum_bank u_dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .rnd_in(rnd_in), .prop_in(prop_in),
    .mask_in(mask_in), .inc_in(inc_in), .clear_in(clear_in),
    .trig_up_out(up_a), .trig_dn_out(dn_a), .trig_total_out(tot_a)
  );

  accum_bank #(.DITHER_W(4), .BIDIR(0)) u_dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .rnd_in(rnd_in), .prop_in(prop_in),
    .mask_in(mask_in), .inc_in(inc_in), .clear_in(clear_in),
    .trig_up_out(up_b), .trig_dn_out(dn_b), .trig_total_out(tot_b)
  );

  accum_bank #(.THRESHOLD(1), .INC_STEP(1), .DEC_STEP(1)) u_dut_c (
    .clk_in(clk_in), .rst_in(rst_in), .rnd_in(rnd_in), .prop_in(prop_in),
    .mask_in(mask_in), .inc_in(inc_in), .clear_in(clear_in),
    .trig_up_out(up_c), .trig_dn_out(dn_c), .trig_total_out(tot_c)
  );

  int checks = 0;
  int errors = 0;

  int thr_m[3]   = '{255, 255, 1};
  int inc_m[3]   = '{8, 8, 1};
  int dec_m[3]   = '{1, 1, 1};
  int dw_m[3]    = '{0, 4, 0};
  int bidir_m[3] = '{1, 0, 1};

  int         cnt_m[3][8];
  int         tot_m[3];
  logic [7:0] up_m[3], dn_m[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Dither: keep the low dw bits, then rotate them left one position at a time.
  function automatic int dither(input int rnd, input int dw, input int lane);
    int v;
    if (dw == 0) return 0;
    v = rnd % (1 << dw);
    for (int s = 0; s < lane % dw; s++) begin
      v = (v * 2) % (1 << dw) + (v / (1 << (dw - 1)));
    end
    return v;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int hits;
      hits = 0;
      up_m[k] = '0;
      dn_m[k] = '0;
      if (!rst_in || clear_in) begin
        for (int l = 0; l < 8; l++) cnt_m[k][l] = 0;
        tot_m[k] = 0;
      end else begin
        for (int l = 0; l < 8; l++) begin
          if (prop_in && mask_in[l]) begin
            int nxt, d;
            nxt = inc_in[l] ? cnt_m[k][l] + inc_m[k] : cnt_m[k][l] - dec_m[k];
            d = dither(int'(rnd_in), dw_m[k], l);
            if (nxt + d >= thr_m[k]) begin
              up_m[k][l] = 1'b1;
              cnt_m[k][l] = nxt - thr_m[k];
              hits++;
            end else if (bidir_m[k] != 0 && nxt - d <= -thr_m[k]) begin
              dn_m[k][l] = 1'b1;
              cnt_m[k][l] = nxt + thr_m[k];
              hits++;
            end else if (bidir_m[k] == 0 && nxt < 0) begin
              cnt_m[k][l] = 0;
            end else begin
              cnt_m[k][l] = nxt;
            end
          end
        end
        tot_m[k] = (tot_m[k] + hits > 65535) ? 65535 : tot_m[k] + hits;
      end
    end
  endtask

  task automatic compare(input string ph);
    check({ph, ":A.up"}, up_a, up_m[0]);
    check({ph, ":A.dn"}, dn_a, dn_m[0]);
    check({ph, ":A.tot"}, tot_a, tot_m[0]);
    check({ph, ":B.up"}, up_b, up_m[1]);
    check({ph, ":B.dn"}, dn_b, dn_m[1]);
    check({ph, ":B.tot"}, tot_b, tot_m[1]);
    check({ph, ":C.up"}, up_c, up_m[2]);
    check({ph, ":C.dn"}, dn_c, dn_m[2]);
    check({ph, ":C.tot"}, tot_c, tot_m[2]);
  endtask

  task automatic cycle(input string ph);
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    compare(ph);
  endtask

  task automatic drive(input logic r, input logic c, input logic p,
                       input logic [7:0] m, input logic [7:0] i, input logic [7:0] d);
    rst_in = r; clear_in = c; prop_in = p; mask_in = m; inc_in = i; rnd_in = d;
  endtask

  initial begin
    int up_seen, dn_seen;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    cycle("reset");
    cycle("reset");
    check("reset:A.up", up_a, 0);
    check("reset:C.tot", tot_c, 0);

    // Lane 0 increments until the first up trigger
    drive(1'b1, 1'b0, 1'b1, 8'h01, 8'hFF, 8'h00);
    for (int n = 0; n < 31; n++) cycle("inc32");
    check("inc32:A.up_early", up_a, 8'h00);
    cycle("inc32");
    check("inc32:A.up", up_a, 8'h01);
    check("inc32:A.tot", tot_a, 1);

    // Lane 1 decrements 255 times from zero
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    cycle("clr");
    drive(1'b1, 1'b0, 1'b1, 8'h02, 8'h00, 8'h00);
    up_seen = 0;
    dn_seen = 0;
    for (int n = 0; n < 255; n++) begin
      cycle("dec255");
      if (up_a != 0) up_seen++;
      if (dn_a[1]) dn_seen++;
    end
    check("dec255:A.dn_last", dn_a, 8'h02);
    check("dec255:A.dn_count", dn_seen, 1);
    check("dec255:A.up_count", up_seen, 0);

    // Up-only lane 2 held at the floor
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    cycle("clr");
    drive(1'b1, 1'b0, 1'b1, 8'h04, 8'h00, 8'h00);
    up_seen = 0;
    for (int n = 0; n < 10; n++) begin
      cycle("floor");
      if ((up_b | dn_b) != 0) up_seen++;
    end
    check("floor:B.pulses", up_seen, 0);
    drive(1'b1, 1'b0, 1'b1, 8'h04, 8'hFF, 8'h00);
    for (int n = 0; n < 31; n++) cycle("floor_inc");
    check("floor_inc:B.up_early", up_b, 8'h00);
    cycle("floor_inc");
    check("floor_inc:B.up", up_b, 8'h04);

    // Dither pushes 248 over the threshold
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    cycle("clr");
    drive(1'b1, 1'b0, 1'b1, 8'h01, 8'hFF, 8'h00);
    for (int n = 0; n < 30; n++) cycle("dith_pre");
    rnd_in = 8'h0F;
    cycle("dith");
    check("dith:B.up", up_b, 8'h01);
    check("dith:A.up", up_a, 8'h00);
    rnd_in = 8'h00;
    for (int n = 0; n < 33; n++) cycle("dith_post");

    // Saturation of the running total
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    cycle("clr");
    drive(1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00);
    for (int n = 0; n < 8191; n++) cycle("sat_fill");
    mask_in = 8'h0F;
    cycle("sat_fill");
    check("sat:C.tot_fffc", tot_c, 16'hFFFC);
    mask_in = 8'hFF;
    cycle("sat");
    check("sat:C.up", up_c, 8'hFF);
    check("sat:C.tot", tot_c, 16'hFFFF);
    cycle("sat_hold");
    check("sat_hold:C.tot", tot_c, 16'hFFFF);

    // Clear and reset win over a triggering update
    clear_in = 1'b1;
    cycle("clr_prop");
    check("clr_prop:C.up", up_c, 8'h00);
    check("clr_prop:C.tot", tot_c, 0);
    clear_in = 1'b0;
    cycle("post_clr");
    check("post_clr:C.up", up_c, 8'hFF);
    rst_in = 1'b0;
    cycle("rst_prop");
    check("rst_prop:C.up", up_c, 8'h00);
    check("rst_prop:C.tot", tot_c, 0);
    rst_in = 1'b1;

    // Random walk with upward bias, occasional clear and reset
    for (int n = 0; n < 1200; n++) begin
      rnd_in   = 8'($urandom);
      prop_in  = ($urandom % 4) != 0;
      mask_in  = 8'($urandom);
      for (int l = 0; l < 8; l++) inc_in[l] = ($urandom % 100) < 80;
      clear_in = ($urandom % 128) == 0;
      rst_in   = ($urandom % 256) != 0;
      cycle("rand_up");
    end

    // Random walk with downward bias for down triggers
    clear_in = 1'b0;
    rst_in   = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      rnd_in  = 8'($urandom);
      prop_in = ($urandom % 8) != 0;
      mask_in = 8'($urandom) | 8'h0F;
      for (int l = 0; l < 8; l++) inc_in[l] = ($urandom % 100) < 5;
      cycle("rand_dn");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_bank.md
ACCUM_BANK -- requirements
Module: accum_bank

Interface
REQ-001 Parameter N_CH, default 8, number of independent accumulator lanes.
REQ-002 Parameter THRESHOLD, default 255, trigger magnitude (>=1).
REQ-003 Parameter INC_STEP, default 8, amount added per increment event (>=1).
REQ-004 Parameter DEC_STEP, default 1, amount subtracted per decrement event (>=1).
REQ-005 Parameter DITHER_W, default 0, dither bits per lane (0..8); 0 disables dithering.
REQ-006 Parameter BIDIR, default 1; 1 = symmetric up/down triggers, 0 = up-only with floor at 0.
REQ-007 One clock; reset is synchronous and active-low.
REQ-008 clk_in  input  1  system clock, all state on rising edge.
REQ-009 rst_in  input  1  synchronous active-low reset.
REQ-010 rnd_in  input  8  random byte, sampled every cycle prop_in=1.
REQ-011 prop_in  input  1  backprop strobe; lanes update only when 1.
REQ-012 mask_in  input  N_CH  per-lane enable; masked lane holds count.
REQ-013 inc_in  input  N_CH  per-lane direction, 1 = increment, 0 = decrement.
REQ-014 clear_in  input  1  zero all counters, synchronous.
REQ-015 trig_up_out  output  N_CH  registered one-cycle up-trigger pulses.
REQ-016 trig_dn_out  output  N_CH  registered one-cycle down-trigger pulses (always 0 when BIDIR=0).
REQ-017 trig_total_out  output  16  saturating count of all triggers since reset/clear.

Function
REQ-018 Each lane SHALL hold a signed counter, COUNT_W = $clog2(THRESHOLD+max(INC_STEP,DEC_STEP)+2^DITHER_W)+2 bits.
REQ-019 Lane update (prop_in=1, mask bit=1): nxt = count + INC_STEP if inc, else count - DEC_STEP, computed at COUNT_W without wrap.
REQ-020 Lane dither d = low DITHER_W bits of rnd_in rotated left by lane index; d=0 when DITHER_W=0.
REQ-021 Up trigger: nxt + d >= THRESHOLD -> count <= nxt - THRESHOLD (residue kept), trig_up pulse next cycle.
REQ-022 Down trigger (BIDIR=1): nxt - d <= -THRESHOLD -> count <= nxt + THRESHOLD, trig_dn pulse next cycle.
REQ-023 BIDIR=0: nxt < 0 clamps count to 0; no down trigger.
REQ-024 No trigger: count <= nxt; at most one trigger per lane per cycle.
REQ-025 Latency: trigger pulse asserted exactly one cycle after the qualifying prop_in cycle; outputs 0 in all other cycles.
REQ-026 prop_in=0 or mask bit=0: count held, trigger outputs 0 for that lane.
REQ-027 clear_in=1 has priority over prop_in: all counts and trig_total_out to 0, no triggers issued that cycle.
REQ-028 trig_total_out adds popcount(trig_up|trig_dn) each cycle, saturating at 16'hFFFF.

Reset
REQ-029 rst_in=0 at a clock edge: all counts 0, trig_up_out=0, trig_dn_out=0, trig_total_out=0; overrides clear_in and prop_in.
REQ-030 Reset asserted mid-update SHALL suppress any pending trigger pulse.

Structure
REQ-031 Package accum_pkg SHALL hold default constants (THRESHOLD, INC_STEP, DEC_STEP) and the COUNT_W width function.
REQ-032 One sub-module accum_lane (single counter + trigger logic) SHALL be instantiated N_CH times via generate; popcount/total in top.

Verification
REQ-033 Defaults, lane 0 inc every cycle: triggers on 32nd prop cycle, count residue 1 (256-255), trig_total_out=1.
REQ-034 BIDIR=1, lane 1 dec 255 cycles from 0: trig_dn pulse once on 255th, count returns 0; trig_up never.
REQ-035 BIDIR=0, lane 2 dec from 0 ten cycles: count stays 0, no pulses.
REQ-036 DITHER_W=4, rnd_in=8'h0F, count 240, inc: nxt 248 +15 >= 255 -> trigger, count -7.
REQ-037 All 8 lanes trigger in the same cycle at trig_total_out=16'hFFFC -> saturates to 16'hFFFF.
REQ-038 clear_in and prop_in together on a triggering cycle: no pulse, all counts 0; rst_in=0 same cycle with prop_in -> all outputs 0 next cycle.
